// File: rtl/alu_pipe.sv
// Registered, handshaked ALU with chained carry flag.
// Define ALU_MUL_EN to make opcode F a WIDTH-cycle shift-add multiplier; otherwise F is a NOP.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             z,
  output logic             c,
  output logic             v,
  output logic             p,
  output logic             busy
);
  localparam int SW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  // Handshake: a transfer happens on any edge where valid and ready are both 1.
  // in_valid is ignored while in_ready is 0; out holds until out_valid & out_ready.
`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, HOLD = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd2} state_t;
`endif

  state_t state_q, state_d;
  logic   cf;
  logic   accept;

  logic [SW-1:0]        shamt;
  logic [2*WIDTH-1:0]   rot;
  logic [WIDTH:0]       add_w;
  logic [WIDTH:0]       sub_w;
  logic                 cin;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c;
  logic                 alu_v;

  assign shamt = b[SW-1:0];
  assign accept = in_valid & in_ready;
  assign out_valid = (state_q == HOLD);
  assign in_ready = (state_q == IDLE) | ((state_q == HOLD) & out_ready);
  assign z = ~|out;
  assign p = ^out;

  // ADC/SBB (opcodes 6,7) share the adder/subtractor with cf as carry/borrow-in.
  always_comb begin
    cin     = opcode[1] & cf;
    add_w   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    sub_w   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
    rot     = {a, a} << shamt;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (opcode)
      4'h0: alu_res = a << shamt;
      4'h1: alu_res = a >> shamt;
      4'h2: alu_res = $signed(a) >>> shamt;
      4'h3: alu_res = rot[2*WIDTH-1:WIDTH];
      4'h4, 4'h6: begin
        {alu_c, alu_res} = add_w;
        alu_v = (a[MSB] == b[MSB]) & (add_w[MSB] != a[MSB]);
      end
      4'h5, 4'h7: begin
        {alu_c, alu_res} = sub_w;
        alu_v = (a[MSB] != b[MSB]) & (sub_w[MSB] != a[MSB]);
      end
      4'h8: alu_res = a & b;
      4'h9: alu_res = a | b;
      4'hA: alu_res = a ^ b;
      4'hB: alu_res = ~a;
      4'hC: alu_res = {{(WIDTH-1){1'b0}}, a == b};
      4'hD: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      4'hE: alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  logic                 is_mul;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [SW-1:0]        cnt;
  logic                 mul_last;

  assign is_mul   = (opcode == 4'hF);
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign mul_last = (state_q == MUL) && (cnt == SW'(WIDTH - 1));
  assign busy     = (state_q == MUL);
`else
  assign busy = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
`ifdef ALU_MUL_EN
        if (in_valid) state_d = is_mul ? MUL : HOLD;
`else
        if (in_valid) state_d = HOLD;
`endif
      end
`ifdef ALU_MUL_EN
      MUL: if (mul_last) state_d = HOLD;
`endif
      HOLD: begin
        if (out_ready) begin
`ifdef ALU_MUL_EN
          if (in_valid) state_d = is_mul ? MUL : HOLD;
`else
          if (in_valid) state_d = HOLD;
`endif
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
      c   <= 1'b0;
      v   <= 1'b0;
      cf  <= 1'b0;
`ifdef ALU_MUL_EN
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
`endif
    end else begin
`ifdef ALU_MUL_EN
      if (accept && !is_mul) begin
`else
      if (accept) begin
`endif
        out <= alu_res;
        c   <= alu_c;
        v   <= alu_v;
        // Only arithmetic results feed the chained carry.
        if (opcode[3:2] == 2'b01) cf <= alu_c;
      end
`ifdef ALU_MUL_EN
      if (accept && is_mul) begin
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        acc    <= '0;
        cnt    <= '0;
      end
      if (state_q == MUL) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + SW'(1);
        if (mul_last) begin
          out <= acc_next[WIDTH-1:0];
          c   <= |acc_next[2*WIDTH-1:WIDTH];
          v   <= 1'b0;
        end
      end
`endif
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=8; MUL checks follow ALU_MUL_EN.
module tb_alu_pipe;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] opcode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       z, c, v, p;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  logic [12:0] obs;
  assign obs = {out_valid, out, z, c, v, p};

  alu_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .z(z), .c(c), .v(v), .p(p), .busy(busy)
  );

  always #5 clk = ~clk;

  // Present one operation for a single edge; returns 1ns after that edge.
  task issue(input logic [3:0] op, input logic [7:0] ia, input logic [7:0] ib);
    opcode   = op;
    a        = ia;
    b        = ib;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task test_reset();
    rst = 1'b1;
    idle_cycle();
    idle_cycle();
    n_vec++;
    if ({obs, busy, in_ready} !== {1'b0, 8'h00, 4'b1000, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset: got ov/out/zcvp=%h busy=%b rdy=%b, want 0/00/1000 busy=0 rdy=1", obs, busy, in_ready);
    end
    rst = 1'b0;
    idle_cycle();
    issue(4'h6, 8'h00, 8'h00);
    n_vec++;
    if (obs !== {1'b1, 8'h00, 4'b1000}) begin
      n_err++;
      $display("FAIL reset_cf_adc: got %h want %h", obs, {1'b1, 8'h00, 4'b1000});
    end
    idle_cycle();
  endtask

  task test_arith();
    issue(4'h4, 8'h7F, 8'h01);
    n_vec++;
    if (obs !== {1'b1, 8'h80, 4'b0011}) begin
      n_err++;
      $display("FAIL add_7f_01: got %h want %h", obs, {1'b1, 8'h80, 4'b0011});
    end
    idle_cycle();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain_to_idle: got out_valid=%b want 0", out_valid);
    end
  endtask

  task test_back_to_back();
    issue(4'h5, 8'h00, 8'h01);
    n_vec++;
    if (obs !== {1'b1, 8'hFF, 4'b0100}) begin
      n_err++;
      $display("FAIL sub_00_01: got %h want %h", obs, {1'b1, 8'hFF, 4'b0100});
    end
    issue(4'h6, 8'h00, 8'h00);
    n_vec++;
    if (obs !== {1'b1, 8'h01, 4'b0001}) begin
      n_err++;
      $display("FAIL adc_after_sub: got %h want %h", obs, {1'b1, 8'h01, 4'b0001});
    end
    issue(4'h5, 8'h00, 8'h01);
    issue(4'h7, 8'h05, 8'h02);
    n_vec++;
    if (obs !== {1'b1, 8'h02, 4'b0001}) begin
      n_err++;
      $display("FAIL sbb_05_02: got %h want %h", obs, {1'b1, 8'h02, 4'b0001});
    end
    issue(4'h4, 8'hFF, 8'h01);
    n_vec++;
    if (obs !== {1'b1, 8'h00, 4'b1100}) begin
      n_err++;
      $display("FAIL add_ff_01: got %h want %h", obs, {1'b1, 8'h00, 4'b1100});
    end
    issue(4'h6, 8'h7F, 8'h00);
    n_vec++;
    if (obs !== {1'b1, 8'h80, 4'b0011}) begin
      n_err++;
      $display("FAIL adc_7f_cin: got %h want %h", obs, {1'b1, 8'h80, 4'b0011});
    end
    issue(4'h5, 8'h00, 8'h01);
    issue(4'h7, 8'h80, 8'h00);
    n_vec++;
    if (obs !== {1'b1, 8'h7F, 4'b0011}) begin
      n_err++;
      $display("FAIL sbb_80_ovf: got %h want %h", obs, {1'b1, 8'h7F, 4'b0011});
    end
    idle_cycle();
  endtask

  task test_shift();
    logic [3:0] ops [6];
    logic [7:0] as  [6];
    logic [7:0] bs  [6];
    logic [7:0] exp [6];
    ops = '{4'h2, 4'h3, 4'h0, 4'h1, 4'h3, 4'h2};
    as  = '{8'h80, 8'h81, 8'h01, 8'h80, 8'h81, 8'h7F};
    bs  = '{8'h09, 8'h01, 8'h0F, 8'h03, 8'h00, 8'h03};
    exp = '{8'hC0, 8'h03, 8'h80, 8'h10, 8'h81, 8'h0F};
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], as[i], bs[i]);
      n_vec++;
      if (obs !== {1'b1, exp[i], 1'b0, 2'b00, ^exp[i]}) begin
        n_err++;
        $display("FAIL shift_%0d op=%h: got %h want %h", i, ops[i], obs, {1'b1, exp[i], 1'b0, 2'b00, ^exp[i]});
      end
    end
    idle_cycle();
  endtask

  task test_logic_cmp();
    logic [3:0] ops [9];
    logic [7:0] as  [9];
    logic [7:0] bs  [9];
    logic [7:0] exp [9];
    ops = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hC, 4'hD, 4'hE, 4'hE};
    as  = '{8'hF0, 8'hF0, 8'hAA, 8'h0F, 8'h05, 8'h05, 8'h01, 8'h01, 8'hFF};
    bs  = '{8'h3C, 8'h0F, 8'hFF, 8'h00, 8'h05, 8'h06, 8'hFF, 8'hFF, 8'h01};
    exp = '{8'h30, 8'hFF, 8'h55, 8'hF0, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01};
    issue(4'h4, 8'hFF, 8'h01);
    for (int i = 0; i < 9; i++) begin
      issue(ops[i], as[i], bs[i]);
      n_vec++;
      if (obs !== {1'b1, exp[i], exp[i] == 8'h00, 2'b00, ^exp[i]}) begin
        n_err++;
        $display("FAIL logic_%0d op=%h: got %h want %h", i, ops[i], obs, {1'b1, exp[i], exp[i] == 8'h00, 2'b00, ^exp[i]});
      end
    end
    idle_cycle();
  endtask

  task test_hold();
    out_ready = 1'b0;
    issue(4'h4, 8'h10, 8'h20);
    opcode   = 4'h4;
    a        = 8'h01;
    b        = 8'h01;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if ({obs, in_ready} !== {1'b1, 8'h30, 4'b0000, 1'b0}) begin
        n_err++;
        $display("FAIL hold_%0d: got %h rdy=%b want %h rdy=0", i, obs, in_ready, {1'b1, 8'h30, 4'b0000});
      end
      idle_cycle();
    end
    out_ready = 1'b1;
    idle_cycle();
    in_valid = 1'b0;
    n_vec++;
    if (obs !== {1'b1, 8'h02, 4'b0001}) begin
      n_err++;
      $display("FAIL hold_release: got %h want %h", obs, {1'b1, 8'h02, 4'b0001});
    end
    idle_cycle();
  endtask

`ifdef ALU_MUL_EN
  task test_mul();
    logic [7:0] as  [3];
    logic [7:0] bs  [3];
    logic [7:0] exp [3];
    logic       expc [3];
    as   = '{8'h10, 8'h0F, 8'hFF};
    bs   = '{8'h10, 8'h03, 8'hFF};
    exp  = '{8'h00, 8'h2D, 8'h01};
    expc = '{1'b1, 1'b0, 1'b1};
    for (int t = 0; t < 3; t++) begin
      issue(4'hF, as[t], bs[t]);
      for (int i = 0; i < 8; i++) begin
        n_vec++;
        if ({busy, out_valid, in_ready} !== 3'b100) begin
          n_err++;
          $display("FAIL mul%0d_busy_%0d: got busy/ov/rdy=%b want 100", t, i, {busy, out_valid, in_ready});
        end
        if (i < 7) idle_cycle();
      end
      idle_cycle();
      n_vec++;
      if ({obs, busy} !== {1'b1, exp[t], exp[t] == 8'h00, expc[t], 1'b0, ^exp[t], 1'b0}) begin
        n_err++;
        $display("FAIL mul%0d_result: got %h busy=%b want %h", t, obs, busy, {1'b1, exp[t], exp[t] == 8'h00, expc[t], 1'b0, ^exp[t]});
      end
      idle_cycle();
    end
  endtask
`else
  task test_mul();
    issue(4'hF, 8'h10, 8'h10);
    n_vec++;
    if ({obs, busy} !== {1'b1, 8'h00, 4'b1000, 1'b0}) begin
      n_err++;
      $display("FAIL mul_nop: got %h busy=%b want %h busy=0", obs, busy, {1'b1, 8'h00, 4'b1000});
    end
    idle_cycle();
  endtask
`endif

  task test_rst_mid();
    logic saw_valid;
    saw_valid = 1'b0;
    issue(4'h4, 8'hFF, 8'h02);
    n_vec++;
    if (obs !== {1'b1, 8'h01, 4'b0101}) begin
      n_err++;
      $display("FAIL add_ff_02: got %h want %h", obs, {1'b1, 8'h01, 4'b0101});
    end
    issue(4'hF, 8'h0F, 8'h03);
`ifdef ALU_MUL_EN
    for (int i = 0; i < 3; i++) begin
      if (out_valid) saw_valid = 1'b1;
      idle_cycle();
    end
`endif
    rst = 1'b1;
    idle_cycle();
    rst = 1'b0;
    n_vec++;
    if ({saw_valid, obs, busy, in_ready} !== {1'b0, 1'b0, 8'h00, 4'b1000, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL rst_mid: got seen=%b %h busy=%b rdy=%b want seen=0 %h busy=0 rdy=1", saw_valid, obs, busy, in_ready, {1'b0, 8'h00, 4'b1000});
    end
    issue(4'h6, 8'h00, 8'h00);
    n_vec++;
    if (obs !== {1'b1, 8'h00, 4'b1000}) begin
      n_err++;
      $display("FAIL rst_cf_clear: got %h want %h", obs, {1'b1, 8'h00, 4'b1000});
    end
    idle_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    opcode    = '0;
    test_reset();
    test_arith();
    test_back_to_back();
    test_shift();
    test_logic_cmp();
    test_hold();
    test_mul();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
